// File: rtl/multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : multiplier_arbiter
// Summary  : Round-robin arbiter sharing one pipelined multiplier among
//            NUM_REQ requesters; a tag pipeline routes each product back.
// Revision : 1.0 - initial release
// ============================================================================
module multiplier_arbiter #(
    parameter int BITWIDTH_INPUT = 32,
    parameter int NUM_REQ        = 4,
    parameter int MUL_LATENCY    = 3
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                hold,
    input  logic [NUM_REQ-1:0]                  req_valid,
    output logic [NUM_REQ-1:0]                  req_ready,
    input  logic [NUM_REQ*BITWIDTH_INPUT-1:0]   req_a,
    input  logic [NUM_REQ*BITWIDTH_INPUT-1:0]   req_b,
    output logic [BITWIDTH_INPUT-1:0]           mul_a,
    output logic [BITWIDTH_INPUT-1:0]           mul_b,
    input  logic [2*BITWIDTH_INPUT-1:0]         mul_q,
    output logic [NUM_REQ-1:0]                  rsp_valid,
    output logic [2*BITWIDTH_INPUT-1:0]         rsp_p,
    output logic [$clog2(NUM_REQ)-1:0]          rsp_id,
    output logic [$clog2(MUL_LATENCY+1)-1:0]    in_flight
);

    localparam int c_W     = BITWIDTH_INPUT;
    localparam int c_ID_W  = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(MUL_LATENCY + 1);

    logic [c_W-1:0]     w_a_arr [NUM_REQ];
    logic [c_W-1:0]     w_b_arr [NUM_REQ];

    logic [c_ID_W-1:0]  r_ptr;
    logic [c_ID_W:0]    w_sum;
    logic [c_ID_W-1:0]  w_cand;
    logic [c_ID_W-1:0]  w_gnt_idx;
    logic               w_found;
    logic               w_grant;

    logic [MUL_LATENCY-1:0]             r_tag_vld;
    logic [MUL_LATENCY-1:0][c_ID_W-1:0] r_tag_id;
    logic                               w_rsp_vld;
    logic [c_ID_W-1:0]                  w_rsp_id;
    logic [c_CNT_W-1:0]                 r_in_flight;

    generate
        for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
            assign w_a_arr[i] = req_a[i*c_W +: c_W];
            assign w_b_arr[i] = req_b[i*c_W +: c_W];
        end
    endgenerate

    // First active requester at or after r_ptr, wrapping past the top index.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_sum     = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (c_ID_W + 1)'(k);
            if (w_sum >= (c_ID_W + 1)'(NUM_REQ)) begin
                w_sum = w_sum - (c_ID_W + 1)'(NUM_REQ);
            end
            w_cand = w_sum[c_ID_W-1:0];
            if (!w_found && req_valid[w_cand]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    // A grant is only ever given to a valid requester, so grant == transfer.
    assign w_grant   = w_found && !hold && !rst;
    assign req_ready = w_grant ? (NUM_REQ'(1) << w_gnt_idx) : '0;
    assign mul_a     = w_grant ? w_a_arr[w_gnt_idx] : '0;
    assign mul_b     = w_grant ? w_b_arr[w_gnt_idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_grant) begin
            r_ptr <= (w_gnt_idx == c_ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        end
    end

    // Tag pipeline runs in lockstep with the external multiplier.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_grant;
            r_tag_id[0]  <= w_gnt_idx;
            for (int s = 1; s < MUL_LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    assign w_rsp_vld = r_tag_vld[MUL_LATENCY-1];
    assign w_rsp_id  = r_tag_id[MUL_LATENCY-1];

    assign rsp_valid = w_rsp_vld ? (NUM_REQ'(1) << w_rsp_id) : '0;
    assign rsp_id    = w_rsp_vld ? w_rsp_id : '0;
    assign rsp_p     = w_rsp_vld ? mul_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_in_flight <= '0;
        end else begin
            case ({w_grant, w_rsp_vld})
                2'b10:   r_in_flight <= r_in_flight + c_CNT_W'(1);
                2'b01:   r_in_flight <= r_in_flight - c_CNT_W'(1);
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    assign in_flight = r_in_flight;

endmodule
`default_nettype wire

// File: tb/tb_multiplier_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_multiplier_arbiter
// Summary  : Directed self-checking bench for multiplier_arbiter with an
//            ideal 3-stage multiplier model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multiplier_arbiter;

    localparam int c_W = 32;
    localparam int c_N = 4;
    localparam int c_L = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic               hold;
    logic [c_N-1:0]     req_valid;
    logic [c_N-1:0]     req_ready;
    logic [c_N*c_W-1:0] req_a;
    logic [c_N*c_W-1:0] req_b;
    logic [c_W-1:0]     mul_a;
    logic [c_W-1:0]     mul_b;
    logic [2*c_W-1:0]   mul_q;
    logic [c_N-1:0]     rsp_valid;
    logic [2*c_W-1:0]   rsp_p;
    logic [1:0]         rsp_id;
    logic [1:0]         in_flight;

    logic [2*c_W-1:0]   r_p1 = '0;
    logic [2*c_W-1:0]   r_p2 = '0;
    logic [2*c_W-1:0]   r_p3 = '0;

    int checks = 0;
    int errors = 0;

    multiplier_arbiter #(
        .BITWIDTH_INPUT (c_W),
        .NUM_REQ        (c_N),
        .MUL_LATENCY    (c_L)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_q     (mul_q),
        .rsp_valid (rsp_valid),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id),
        .in_flight (in_flight)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        r_p1 <= {32'b0, mul_a} * {32'b0, mul_b};
        r_p2 <= r_p1;
        r_p3 <= r_p2;
    end
    assign mul_q = r_p3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        hold      = 1'b0;
        req_valid = 4'b1111;
        req_a     = {c_N{32'hDEADBEEF}};
        req_b     = {c_N{32'h12345678}};
        tick();
        tick();
        checks++;
        if ({req_ready, rsp_valid, rsp_id, in_flight, mul_a, mul_b, rsp_p} !== '0) begin
            errors++;
            $display("FAIL reset got rdy=%b v=%b id=%0d f=%0d ma=%h mb=%h p=%h exp all zero",
                     req_ready, rsp_valid, rsp_id, in_flight, mul_a, mul_b, rsp_p);
        end
        req_valid = '0;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [3:0]  e_v;
        logic [1:0]  e_f;
        logic [63:0] e_p;
        req_valid = 4'b0001;
        req_a[0 +: c_W] = 32'd7;
        req_b[0 +: c_W] = 32'd9;
        #1;
        checks++;
        if ({req_ready, mul_a, mul_b, in_flight} !== {4'b0001, 32'd7, 32'd9, 2'd0}) begin
            errors++;
            $display("FAIL single_issue got rdy=%b ma=%0d mb=%0d f=%0d exp rdy=0001 ma=7 mb=9 f=0",
                     req_ready, mul_a, mul_b, in_flight);
        end
        tick();
        req_valid = '0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            e_v = (c == 3) ? 4'b0001 : 4'b0000;
            e_p = (c == 3) ? 64'd63 : 64'd0;
            e_f = (c == 4) ? 2'd0 : 2'd1;
            checks++;
            if ({rsp_valid, rsp_id, in_flight, rsp_p} !== {e_v, 2'd0, e_f, e_p}) begin
                errors++;
                $display("FAIL single_c%0d got v=%b id=%0d f=%0d p=%h exp v=%b id=0 f=%0d p=%h",
                         c, rsp_valid, rsp_id, in_flight, rsp_p, e_v, e_f, e_p);
            end
            tick();
        end
    endtask

    task automatic test_all_four();
        logic [63:0] e_prod [4];
        logic [3:0]  e_rdy;
        logic [3:0]  e_v;
        logic [1:0]  e_id;
        logic [1:0]  e_f;
        logic [63:0] e_p;
        e_prod = '{64'd20, 64'd60, 64'd120, 64'd200};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_a = {32'd5, 32'd4, 32'd3, 32'd2};
        req_b = {32'd40, 32'd30, 32'd20, 32'd10};
        for (int c = 0; c < 12; c++) begin
            req_valid = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            e_rdy = (c < 8) ? (4'b0001 << (c % 4)) : 4'b0000;
            e_f   = (c < 3) ? 2'(c) : ((c <= 8) ? 2'd3 : 2'(11 - c));
            if (c >= 3 && c <= 10) begin
                e_id = 2'((c - 3) % 4);
                e_v  = 4'b0001 << e_id;
                e_p  = e_prod[e_id];
            end else begin
                e_id = 2'd0;
                e_v  = 4'b0000;
                e_p  = 64'd0;
            end
            checks++;
            if ({req_ready, rsp_valid, rsp_id, in_flight, rsp_p} !== {e_rdy, e_v, e_id, e_f, e_p}) begin
                errors++;
                $display("FAIL all_four_c%0d got rdy=%b v=%b id=%0d f=%0d p=%0d exp rdy=%b v=%b id=%0d f=%0d p=%0d",
                         c, req_ready, rsp_valid, rsp_id, in_flight, rsp_p, e_rdy, e_v, e_id, e_f, e_p);
            end
            tick();
        end
    endtask

    task automatic test_extremes();
        logic [3:0]  e_rdy [6];
        logic [3:0]  e_v   [6];
        logic [1:0]  e_id  [6];
        logic [1:0]  e_f   [6];
        logic [63:0] e_p   [6];
        e_rdy = '{4'b0001, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        e_v   = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 4'b0000};
        e_id  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};
        e_f   = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
        e_p   = '{64'd0, 64'd0, 64'd0, 64'hFFFFFFFE00000001, 64'd0, 64'd0};
        req_a[0 +: c_W]   = 32'hFFFFFFFF;
        req_b[0 +: c_W]   = 32'hFFFFFFFF;
        req_a[c_W +: c_W] = 32'd0;
        req_b[c_W +: c_W] = 32'hFFFFFFFF;
        for (int c = 0; c < 6; c++) begin
            req_valid = (c == 0) ? 4'b0001 : ((c == 1) ? 4'b0010 : 4'b0000);
            #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_id, in_flight, rsp_p} !== {e_rdy[c], e_v[c], e_id[c], e_f[c], e_p[c]}) begin
                errors++;
                $display("FAIL extremes_c%0d got rdy=%b v=%b id=%0d f=%0d p=%h exp rdy=%b v=%b id=%0d f=%0d p=%h",
                         c, req_ready, rsp_valid, rsp_id, in_flight, rsp_p, e_rdy[c], e_v[c], e_id[c], e_f[c], e_p[c]);
            end
            tick();
        end
    endtask

    task automatic test_hold();
        logic [3:0]  e_rdy [11];
        logic [3:0]  e_v   [11];
        logic [1:0]  e_id  [11];
        logic [1:0]  e_f   [11];
        logic [63:0] e_p   [11];
        logic [31:0] e_ma  [11];
        logic [3:0]  in_v  [11];
        e_rdy = '{4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        e_v   = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000};
        e_id  = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd0};
        e_f   = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd0};
        e_p   = '{64'd0, 64'd0, 64'd0, 64'd42, 64'd143, 64'd0, 64'd0, 64'd0, 64'd0, 64'd25, 64'd0};
        e_ma  = '{32'd6, 32'd11, 32'd0, 32'd0, 32'd0, 32'd0, 32'd5, 32'd0, 32'd0, 32'd0, 32'd0};
        in_v  = '{4'b0010, 4'b0100, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        req_a = {32'd5, 32'd11, 32'd6, 32'd1};
        req_b = {32'd5, 32'd13, 32'd7, 32'd1};
        for (int c = 0; c < 11; c++) begin
            req_valid = in_v[c];
            hold      = (c >= 2 && c <= 5);
            #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_id, in_flight, rsp_p, mul_a} !==
                {e_rdy[c], e_v[c], e_id[c], e_f[c], e_p[c], e_ma[c]}) begin
                errors++;
                $display("FAIL hold_c%0d got rdy=%b v=%b id=%0d f=%0d p=%0d ma=%0d exp rdy=%b v=%b id=%0d f=%0d p=%0d ma=%0d",
                         c, req_ready, rsp_valid, rsp_id, in_flight, rsp_p, mul_a,
                         e_rdy[c], e_v[c], e_id[c], e_f[c], e_p[c], e_ma[c]);
            end
            tick();
        end
        hold = 1'b0;
    endtask

    task automatic test_reset_midflight();
        logic [3:0]  e_v;
        logic [1:0]  e_f;
        logic [63:0] e_p;
        req_a = {32'd4, 32'd9, 32'd2, 32'd1};
        req_b = {32'd1, 32'd9, 32'd1, 32'd1};
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b1111;
            #1;
            checks++;
            if (req_ready !== (4'b0001 << c)) begin
                errors++;
                $display("FAIL rstmid_issue_c%0d got rdy=%b exp rdy=%b", c, req_ready, 4'b0001 << c);
            end
            tick();
        end
        checks++;
        if (in_flight !== 2'd3) begin
            errors++;
            $display("FAIL rstmid_preflight got f=%0d exp f=3", in_flight);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_id, in_flight, rsp_p} !== '0) begin
            errors++;
            $display("FAIL rstmid_inreset got rdy=%b v=%b id=%0d f=%0d p=%h exp all zero",
                     req_ready, rsp_valid, rsp_id, in_flight, rsp_p);
        end
        tick();
        rst = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            req_valid = (c == 4) ? 4'b1100 : 4'b0000;
            #1;
            e_v = (c == 7) ? 4'b0100 : 4'b0000;
            e_p = (c == 7) ? 64'd81 : 64'd0;
            e_f = (c == 4 || c == 8) ? 2'd0 : 2'd1;
            checks++;
            if ({req_ready, rsp_valid, rsp_id, in_flight, rsp_p} !==
                {((c == 4) ? 4'b0100 : 4'b0000), e_v, ((c == 7) ? 2'd2 : 2'd0), e_f, e_p}) begin
                errors++;
                $display("FAIL rstmid_c%0d got rdy=%b v=%b id=%0d f=%0d p=%0d exp rdy=%b v=%b id=%0d f=%0d p=%0d",
                         c, req_ready, rsp_valid, rsp_id, in_flight, rsp_p,
                         (c == 4) ? 4'b0100 : 4'b0000, e_v, (c == 7) ? 2'd2 : 2'd0, e_f, e_p);
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        logic [3:0]  e_rdy [6];
        logic [3:0]  e_v   [6];
        logic [1:0]  e_id  [6];
        logic [1:0]  e_f   [6];
        logic [63:0] e_p   [6];
        logic [31:0] e_ma  [6];
        e_rdy = '{4'b1000, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        e_v   = '{4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0000};
        e_id  = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd0, 2'd0};
        e_f   = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
        e_p   = '{64'd0, 64'd0, 64'd0, 64'd20, 64'd6, 64'd0};
        e_ma  = '{32'd4, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
        req_a = {32'd4, 32'd0, 32'd0, 32'd2};
        req_b = {32'd5, 32'd0, 32'd0, 32'd3};
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 2) ? 4'b1001 : 4'b0000;
            #1;
            checks++;
            if ({req_ready, rsp_valid, rsp_id, in_flight, rsp_p, mul_a} !==
                {e_rdy[c], e_v[c], e_id[c], e_f[c], e_p[c], e_ma[c]}) begin
                errors++;
                $display("FAIL wrap_c%0d got rdy=%b v=%b id=%0d f=%0d p=%0d ma=%0d exp rdy=%b v=%b id=%0d f=%0d p=%0d ma=%0d",
                         c, req_ready, rsp_valid, rsp_id, in_flight, rsp_p, mul_a,
                         e_rdy[c], e_v[c], e_id[c], e_f[c], e_p[c], e_ma[c]);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_four();
        test_extremes();
        test_hold();
        test_reset_midflight();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiplier_arbiter.md
MULTIPLIER_ARBITER -- requirements
Module: multiplier_arbiter

Interface
REQ-001 SHALL have parameter BITWIDTH_INPUT, default 32, the operand width W of the shared multiplier.
REQ-002 SHALL have parameter NUM_REQ, default 4, the requester count N (N >= 2).
REQ-003 SHALL have parameter MUL_LATENCY, default 3, the cycles from operands driven on mul_a/mul_b to the product on mul_q (>= 1).
REQ-004 SHALL have port clk input 1 for the single clock; all state SHALL update on the rising edge.
REQ-005 SHALL have port rst input 1 for reset, asynchronous and active-high.
REQ-006 SHALL have port hold input 1 that blocks new grants while high.
REQ-007 SHALL have port req_valid input N for one operation request per requester.
REQ-008 SHALL have port req_ready output N for one grant per requester.
REQ-009 SHALL have port req_a input N*W carrying requester i's operand a in bits [i*W +: W].
REQ-010 SHALL have port req_b input N*W carrying requester i's operand b, packed as req_a.
REQ-011 SHALL have port mul_a output W, operand a to the shared multiplier.
REQ-012 SHALL have port mul_b output W, operand b to the shared multiplier.
REQ-013 SHALL have port mul_q input 2W, the product from the shared multiplier.
REQ-014 SHALL have port rsp_valid output N, one-cycle result strobe per requester.
REQ-015 SHALL have port rsp_p output 2W, the result shared by all requesters.
REQ-016 SHALL have port rsp_id output clog2(N), the requester index of the current result.
REQ-017 SHALL have port in_flight output clog2(MUL_LATENCY+1), the count of issued operations not yet returned.

Function
REQ-018 SHALL assert at most one req_ready bit per cycle; a transfer occurs when req_valid[i] and req_ready[i] are both high at a rising edge.
REQ-019 SHALL decide req_ready combinationally from req_valid, hold and the round-robin pointer ptr; the first requester with req_valid high, searching from index ptr upward and wrapping N-1 to 0, SHALL be granted.
REQ-020 SHALL drive req_ready to all zeros while hold=1 or rst=1.
REQ-021 SHALL move ptr to (granted index + 1) mod N on each transfer and SHALL leave ptr unchanged in cycles without a transfer.
REQ-022 SHALL drive mul_a/mul_b combinationally with the granted requester's operands, and with zero when there is no grant.
REQ-023 SHALL keep a tag shift register of MUL_LATENCY stages, each holding a valid bit and a requester index; stage 0 SHALL load {transfer, granted index} every cycle.
REQ-024 SHALL, when the final tag stage is valid, assert rsp_valid[id] for exactly that cycle, drive rsp_id=id and rsp_p=mul_q.
REQ-025 SHALL produce each result MUL_LATENCY cycles after its transfer edge, in issue order, one per cycle at full throughput.
REQ-026 SHALL hold rsp_valid at zero, and rsp_p and rsp_id at zero, in cycles without a valid final tag.
REQ-027 SHALL keep in_flight equal to the number of valid tag stages: +1 on a transfer, -1 on a result, unchanged when both happen in the same cycle.
REQ-028 SHALL have no response backpressure; each requester SHALL capture its result in the rsp_valid cycle.
REQ-029 SHALL keep already-issued operations draining normally while hold=1.
REQ-030 SHALL, when a requester holds req_valid high, keep its wait to at most N-1 grants to other requesters.

Reset
REQ-031 SHALL, while rst=1, clear all tag valid bits and indices, set ptr=0, and force rsp_valid=0, rsp_p=0, rsp_id=0, in_flight=0 and req_ready=0.
REQ-032 SHALL, if rst is asserted mid-operation, discard all in-flight results, so that no rsp_valid occurs for any operation issued before the reset.
REQ-033 SHALL allow a grant in the first clock edge after rst deasserts.

Verification (W=32, N=4, MUL_LATENCY=3, ideal 3-stage multiplier model)
REQ-034 SHALL cover a single request: req_valid=0001 with a0=7, b0=9 -> req_ready=0001 on that cycle; 3 cycles later rsp_valid=0001, rsp_id=0, rsp_p=63; in_flight goes 1,1,1,0.
REQ-035 SHALL cover all four requesting continuously from ptr=0: grants 0,1,2,3,0,... one per cycle; rsp_id follows 0,1,2,3 starting 3 cycles later; in_flight holds at 3.
REQ-036 SHALL cover operand extremes: a=b=32'hFFFFFFFF -> rsp_p=64'hFFFFFFFE00000001; a=0, b=32'hFFFFFFFF -> rsp_p=0.
REQ-037 SHALL cover hold: hold=1 with req_valid=1111 and 2 operations in flight -> req_ready=0000, both results still return, in_flight reaches 0; on release the grant resumes at ptr.
REQ-038 SHALL cover reset mid-flight: rst pulse with in_flight=3 -> no rsp_valid for those operations, ptr=0, and the next grant goes to the lowest-indexed active requester.
REQ-039 SHALL cover the pointer wrap: ptr=3 with req_valid=1001 -> grant 3, then 0.
